// File: rtl/calc_decode_pkg.sv
// Shared types and default widths for the calculator instruction decode queue.
package calc_decode_pkg;

  localparam int DEF_FUNCT_W = 3;
  localparam int DEF_IMM_W   = 16;
  localparam int DEF_OPND_W  = 32;
  localparam int DEF_NUM_OPS = 6;
  localparam int DEF_DEPTH   = 4;

  typedef enum logic [DEF_FUNCT_W-1:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3,
    AND = 3'd4,
    OR  = 3'd5
  } funct_e;

  // Field order matches the packed entry vector stored in the FIFO (funct at MSB, illegal at LSB)
  typedef struct packed {
    logic [DEF_FUNCT_W-1:0] funct;
    logic [DEF_OPND_W-1:0]  imm_a;
    logic [DEF_OPND_W-1:0]  imm_b;
    logic                   illegal;
  } decoded_t;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  function automatic int entry_width(input int funct_w, input int opnd_w);
    return funct_w + 2 * opnd_w + 1;
  endfunction

endpackage

// File: rtl/decode_fifo.sv
// Generic DEPTH x WIDTH FIFO with occupancy FSM, pointers and count; flush has priority.
//
// state       | meaning
// OCC_EMPTY   | count = 0, nothing to pop
// OCC_PARTIAL | 0 < count < DEPTH
// OCC_FULL    | count = DEPTH, pushes refused
module decode_fifo
  import calc_decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  occ_e               state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];
  logic               do_push, do_pop;

  assign do_push = push_valid && push_ready;
  assign do_pop  = pop_valid && pop_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= OCC_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY:   if (do_push) state_d = OCC_PARTIAL;
        OCC_PARTIAL: begin
          if (do_push && !do_pop && count_q == CNT_W'(DEPTH - 1))
            state_d = OCC_FULL;
          else if (do_pop && !do_push && count_q == CNT_W'(1))
            state_d = OCC_EMPTY;
        end
        OCC_FULL:    if (do_pop) state_d = OCC_PARTIAL;
        default:     state_d = OCC_EMPTY;
      endcase
    end
  end

  always_comb begin
    push_ready = (state_q != OCC_FULL);
    pop_valid  = (state_q != OCC_EMPTY);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; readers only look at it while pop_valid is set
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/instr_decode_queue.sv
// Decodes packed {immB, immA, funct} instructions and queues them for the control FSM.
// Define IMM_SIGN_EXT_EN to sign-extend the immediates; zero-extension otherwise.
module instr_decode_queue
  import calc_decode_pkg::*;
#(
  parameter int FUNCT_W = DEF_FUNCT_W,
  parameter int IMM_W   = DEF_IMM_W,
  parameter int OPND_W  = DEF_OPND_W,
  parameter int NUM_OPS = DEF_NUM_OPS,
  parameter int DEPTH   = DEF_DEPTH,
  localparam int INSTR_W = FUNCT_W + 2 * IMM_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INSTR_W-1:0]      instruction,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FUNCT_W-1:0]      funct,
  output logic [OPND_W-1:0]       imm_a,
  output logic [OPND_W-1:0]       imm_b,
  output logic                    illegal,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int ENTRY_W = entry_width(FUNCT_W, OPND_W);

  logic [FUNCT_W-1:0] in_funct;
  logic [IMM_W-1:0]   in_imm_a, in_imm_b;
  logic [OPND_W-1:0]  in_imm_a_ext, in_imm_b_ext;
  logic               in_illegal;
  logic [ENTRY_W-1:0] push_entry, head_entry;

  always_comb begin
    in_funct = instruction[FUNCT_W-1:0];
    in_imm_a = instruction[FUNCT_W +: IMM_W];
    in_imm_b = instruction[FUNCT_W + IMM_W +: IMM_W];
`ifdef IMM_SIGN_EXT_EN
    in_imm_a_ext = OPND_W'($signed(in_imm_a));
    in_imm_b_ext = OPND_W'($signed(in_imm_b));
`else
    in_imm_a_ext = OPND_W'(in_imm_a);
    in_imm_b_ext = OPND_W'(in_imm_b);
`endif
    in_illegal = (32'(in_funct) >= NUM_OPS);
    push_entry = {in_funct, in_imm_a_ext, in_imm_b_ext, in_illegal};
  end

  decode_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (push_entry),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (head_entry),
    .count      (count)
  );

  // Empty queue presents an all-zero entry rather than stale storage
  always_comb begin
    funct   = '0;
    imm_a   = '0;
    imm_b   = '0;
    illegal = 1'b0;
    if (out_valid) begin
      funct   = head_entry[ENTRY_W-1 -: FUNCT_W];
      imm_a   = head_entry[1 + OPND_W +: OPND_W];
      imm_b   = head_entry[1 +: OPND_W];
      illegal = head_entry[0];
    end
  end

endmodule

// File: tb/tb_instr_decode_queue.sv
// Self-checking bench for instr_decode_queue against a queue-based reference model.
module tb_instr_decode_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [34:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  funct;
  logic [31:0] imm_a;
  logic [31:0] imm_b;
  logic        illegal;
  logic [2:0]  count;

  instr_decode_queue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .funct       (funct),
    .imm_a       (imm_a),
    .imm_b       (imm_b),
    .illegal     (illegal),
    .count       (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [31:0] ext(input logic [15:0] v);
`ifdef IMM_SIGN_EXT_EN
    return (v[15]) ? (32'hFFFF0000 | {16'h0, v}) : {16'h0, v};
`else
    return {16'h0, v};
`endif
  endfunction

  function automatic exp_t decode(input logic [34:0] ins);
    exp_t d;
    d.f   = ins[2:0];
    d.a   = ext(ins[18:3]);
    d.b   = ext(ins[34:19]);
    d.ill = (int'(ins[2:0]) >= 6);
    return d;
  endfunction

  function automatic logic [34:0] mk(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
    return {b, a, f};
  endfunction

  function automatic logic [34:0] rand_instr();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[34:0];
  endfunction

  task automatic tick(input logic v, input logic [34:0] ins, input logic ordy, input logic fl);
    bit do_pop, do_push;
    in_valid    = v;
    instruction = ins;
    out_ready   = ordy;
    flush       = fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      do_pop  = (q.size() > 0) && ordy;
      do_push = v && (q.size() < 4);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(decode(ins));
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instruction = '0;
    #3;
    n_checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1)
      $display("FAIL reset_flags: out_valid=%b count=%0d in_ready=%b want 0/0/1", out_valid, count, in_ready);
    else n_pass++;
    n_checks++;
    if ({funct, imm_a, imm_b, illegal} !== 68'h0)
      $display("FAIL reset_fields: got %h want 0", {funct, imm_a, imm_b, illegal});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [31:0] want_b;
`ifdef IMM_SIGN_EXT_EN
    want_b = 32'hFFFFFFFE;
`else
    want_b = 32'h0000FFFE;
`endif
    tick(1'b1, mk(3'd1, 16'h0005, 16'hFFFE), 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || funct !== 3'd1 || count !== 3'd1)
      $display("FAIL single_head: valid=%b funct=%0d count=%0d want 1/1/1", out_valid, funct, count);
    else n_pass++;
    n_checks++;
    if (imm_a !== 32'h5 || imm_b !== want_b)
      $display("FAIL single_imm: imm_a=%h imm_b=%h want 00000005/%h", imm_a, imm_b, want_b);
    else n_pass++;
    tick(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || funct !== 3'd0 || imm_b !== 32'h0)
      $display("FAIL single_drain: valid=%b funct=%0d imm_b=%h want 0/0/0", out_valid, funct, imm_b);
    else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) tick(1'b1, rand_instr(), 1'b0, 1'b0);
    n_checks++;
    if (count !== 3'd4 || in_ready !== 1'b0)
      $display("FAIL fill_full: count=%0d in_ready=%b want 4/0", count, in_ready);
    else n_pass++;
    tick(1'b1, rand_instr(), 1'b0, 1'b0);
    n_checks++;
    if (count !== 3'd4 || q.size() != 4 || funct !== q[0].f || imm_a !== q[0].a)
      $display("FAIL fill_fifth: count=%0d funct=%0d imm_a=%h want 4/%0d/%h", count, funct, imm_a, q[0].f, q[0].a);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || funct !== q[0].f || imm_a !== q[0].a || imm_b !== q[0].b || illegal !== q[0].ill)
        $display("FAIL fill_order%0d: got %0d/%h/%h/%b want %0d/%h/%h/%b", i, funct, imm_a, imm_b, illegal,
                 q[0].f, q[0].a, q[0].b, q[0].ill);
      else n_pass++;
      tick(1'b0, '0, 1'b1, 1'b0);
    end
    n_checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1)
      $display("FAIL fill_empty: valid=%b count=%0d in_ready=%b want 0/0/1", out_valid, count, in_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    tick(1'b1, rand_instr(), 1'b0, 1'b0);
    tick(1'b1, rand_instr(), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, rand_instr(), 1'b1, 1'b0);
      n_checks++;
      if (count !== 3'd2 || funct !== q[0].f || imm_a !== q[0].a || imm_b !== q[0].b)
        $display("FAIL b2b_%0d: count=%0d head=%0d/%h/%h want 2/%0d/%h/%h", i, count, funct, imm_a, imm_b,
                 q[0].f, q[0].a, q[0].b);
      else n_pass++;
    end
    tick(1'b0, '0, 1'b1, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_illegal();
    tick(1'b1, mk(3'd7, 16'h1234, 16'h8001), 1'b0, 1'b0);
    n_checks++;
    if (illegal !== 1'b1 || funct !== 3'd7)
      $display("FAIL illegal_f7: illegal=%b funct=%0d want 1/7", illegal, funct);
    else n_pass++;
    tick(1'b1, mk(3'd5, 16'h00AA, 16'h0055), 1'b1, 1'b0);
    n_checks++;
    if (illegal !== 1'b0 || funct !== 3'd5 || count !== 3'd1)
      $display("FAIL illegal_f5: illegal=%b funct=%0d count=%0d want 0/5/1", illegal, funct, count);
    else n_pass++;
    tick(1'b1, mk(3'd6, 16'h0000, 16'h0000), 1'b1, 1'b0);
    n_checks++;
    if (illegal !== 1'b1 || funct !== 3'd6)
      $display("FAIL illegal_f6: illegal=%b funct=%0d want 1/6", illegal, funct);
    else n_pass++;
    tick(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) tick(1'b1, rand_instr(), 1'b0, 1'b0);
    n_checks++;
    if (count !== 3'd3)
      $display("FAIL flush_pre: count=%0d want 3", count);
    else n_pass++;
    tick(1'b1, rand_instr(), 1'b1, 1'b1);
    n_checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_post: count=%0d valid=%b in_ready=%b want 0/0/1", count, out_valid, in_ready);
    else n_pass++;
    tick(1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (count !== 3'd0 || out_valid !== 1'b0)
      $display("FAIL flush_hold: count=%0d valid=%b want 0/0", count, out_valid);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    tick(1'b1, rand_instr(), 1'b0, 1'b0);
    tick(1'b1, rand_instr(), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1)
      $display("FAIL async_reset: valid=%b count=%0d in_ready=%b want 0/0/1", out_valid, count, in_ready);
    else n_pass++;
    q.delete();
    #1 rst_n = 1'b1;
    tick(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (count !== 3'd0 || out_valid !== 1'b0)
      $display("FAIL async_after: count=%0d valid=%b want 0/0", count, out_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 300; i++) begin
      logic        v, r, fl, ev;
      logic [2:0]  ef;
      logic [31:0] ea, eb;
      logic        ei;
      v  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 24) == 0);
      tick(v, rand_instr(), r, fl);
      ev = (q.size() != 0);
      ef = ev ? q[0].f : 3'd0;
      ea = ev ? q[0].a : 32'd0;
      eb = ev ? q[0].b : 32'd0;
      ei = ev ? q[0].ill : 1'b0;
      n_checks++;
      if (out_valid !== ev || in_ready !== (q.size() != 4) || count !== 3'(q.size()) ||
          funct !== ef || imm_a !== ea || imm_b !== eb || illegal !== ei) begin
        if (errs < 10)
          $display("FAIL random_%0d: v=%b rdy=%b cnt=%0d %0d/%h/%h/%b want v=%b cnt=%0d %0d/%h/%h/%b", i,
                   out_valid, in_ready, count, funct, imm_a, imm_b, illegal, ev, q.size(), ef, ea, eb, ei);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
